// File: rtl/seq_stream_checker_if.sv
// Valid/ready beat channel carrying one sequence value per accepted beat.
interface seq_stream_checker_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/seq_stream_checker.sv
// Receives an incrementing-counter stream, locks onto it and reports gaps,
// repeats and corruption; escalates to a sticky fault on consecutive misses.
module seq_stream_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_LIMIT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    seq_stream_checker_if.slave in_if,
    output logic             locked_o,
    output logic             error_o,
    output logic             fault_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [7:0]       err_count_o,
    output logic [15:0]      sample_count_o
);
    localparam int unsigned RW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [RW-1:0]    run_q, run_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [15:0]      sample_count_q, sample_count_d;
    logic             in_ready_q, in_ready_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic             fault_q, fault_d;

    logic             accept;
    logic             match;
    logic [RW-1:0]    run_inc;
    logic [MW-1:0]    miss_inc;

    assign accept   = in_if.valid & in_ready_q;
    assign match    = (in_if.data == expected_q);
    assign run_inc  = run_q + RW'(1);
    assign miss_inc = miss_q + MW'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        expected_d     = expected_q;
        run_d          = run_q;
        miss_d         = miss_q;
        err_count_d    = err_count_q;
        sample_count_d = sample_count_q;
        error_d        = 1'b0;

        if (clear_i) begin
            state_d        = ST_IDLE;
            expected_d     = '0;
            run_d          = '0;
            miss_d         = '0;
            err_count_d    = '0;
            sample_count_d = '0;
        end else if (accept) begin
            sample_count_d = sample_count_q + 16'd1;
            // On a match data+1 equals expected+1; on a miss this resyncs.
            expected_d     = in_if.data + WIDTH'(1);
            case (state_q)
                ST_IDLE: begin
                    run_d   = RW'(1);
                    miss_d  = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                        if (state_q == ST_ACQUIRE) begin
                            run_d = run_inc;
                            if (run_inc >= RW'(LOCK_COUNT)) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end else begin
                        error_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        miss_d  = miss_inc;
                        run_d   = RW'(1);
                        state_d = (miss_inc == MW'(ERR_LIMIT)) ? ST_FAULT : ST_ACQUIRE;
                    end
                end
                default: ;
            endcase
        end

        in_ready_d = (state_d != ST_FAULT);
        locked_d   = (state_d == ST_LOCKED);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            expected_q     <= '0;
            run_q          <= '0;
            miss_q         <= '0;
            err_count_q    <= '0;
            sample_count_q <= '0;
            in_ready_q     <= 1'b0;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            run_q          <= run_d;
            miss_q         <= miss_d;
            err_count_q    <= err_count_d;
            sample_count_q <= sample_count_d;
            in_ready_q     <= in_ready_d;
            locked_q       <= locked_d;
            error_q        <= error_d;
            fault_q        <= fault_d;
        end
    end

    assign in_if.ready    = in_ready_q;
    assign locked_o       = locked_q;
    assign error_o        = error_q;
    assign fault_o        = fault_q;
    assign expected_o     = expected_q;
    assign err_count_o    = err_count_q;
    assign sample_count_o = sample_count_q;
endmodule

// File: tb/tb_seq_stream_checker.sv
// Scoreboard bench for seq_stream_checker: directed beats push hand-computed
// responses; a monitor pops and compares after every accepted beat.
module tb_seq_stream_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        locked, error, fault;
    logic [7:0]  expected;
    logic [7:0]  err_count;
    logic [15:0] sample_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic        lck;
        logic        flt;
        logic [7:0]  exp_v;
        logic [7:0]  ecnt;
        logic [15:0] scnt;
    } resp_t;

    resp_t exp_q[$];
    logic  acc_q = 1'b0;

    seq_stream_checker_if #(.WIDTH(8)) bus ();

    seq_stream_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_LIMIT(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear),
        .in_if          (bus.slave),
        .locked_o       (locked),
        .error_o        (error),
        .fault_o        (fault),
        .expected_o     (expected),
        .err_count_o    (err_count),
        .sample_count_o (sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Accept detection at the active edge; response checked on the falling edge.
    always @(posedge clk) acc_q <= bus.valid && bus.ready && rst_n && !clear;

    always @(negedge clk) begin
        resp_t got, req;
        got = {error, locked, fault, expected, err_count, sample_count};
        if (acc_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got %0h with empty scoreboard", got);
            end else begin
                req = exp_q.pop_front();
                chk("beat_resp", 32'(got), 32'(req));
                chk("beat_scnt", 32'(got.scnt), 32'(req.scnt));
            end
        end else if (rst_n) begin
            chk("idle_error_low", 32'(error), 32'd0);
        end
    end

    task automatic beat(input logic [7:0] d, input logic e, input logic l, input logic f,
                        input logic [7:0] x, input logic [7:0] ec, input logic [15:0] sc);
        resp_t r;
        r = {e, l, f, x, ec, sc};
        exp_q.push_back(r);
        bus.valid = 1'b1;
        bus.data  = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        bus.valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_flags"}, 32'({locked, error, fault}), 32'd0);
        chk({tag, "_expected"}, 32'(expected), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_sample_count"}, 32'(sample_count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(bus.ready), 32'd1);

        // Basic lock
        beat(8'd10, 0, 0, 0, 8'd11, 8'd0, 16'd1);
        beat(8'd11, 0, 0, 0, 8'd12, 8'd0, 16'd2);
        idle(2);
        beat(8'd12, 0, 0, 0, 8'd13, 8'd0, 16'd3);
        beat(8'd13, 0, 1, 0, 8'd14, 8'd0, 16'd4);
        for (int v = 14; v <= 21; v++)
            beat(8'(v), 0, 1, 0, 8'(v + 1), 8'd0, 16'(v - 9));
        // Skipped value, then relock
        beat(8'd23, 1, 0, 0, 8'd24, 8'd1, 16'd13);
        idle(1);
        beat(8'd24, 0, 0, 0, 8'd25, 8'd1, 16'd14);
        beat(8'd25, 0, 0, 0, 8'd26, 8'd1, 16'd15);
        beat(8'd26, 0, 1, 0, 8'd27, 8'd1, 16'd16);
        beat(8'd27, 0, 1, 0, 8'd28, 8'd1, 16'd17);

        // Wrap 255 -> 0
        do_clear();
        beat(8'd254, 0, 0, 0, 8'd255, 8'd0, 16'd1);
        beat(8'd255, 0, 0, 0, 8'd0,   8'd0, 16'd2);
        beat(8'd0,   0, 0, 0, 8'd1,   8'd0, 16'd3);
        beat(8'd1,   0, 1, 0, 8'd2,   8'd0, 16'd4);

        // Three consecutive mismatches force fault
        do_clear();
        beat(8'd5, 0, 0, 0, 8'd6,  8'd0, 16'd1);
        beat(8'd6, 0, 0, 0, 8'd7,  8'd0, 16'd2);
        beat(8'd7, 0, 0, 0, 8'd8,  8'd0, 16'd3);
        beat(8'd8, 0, 1, 0, 8'd9,  8'd0, 16'd4);
        beat(8'd9, 0, 1, 0, 8'd10, 8'd0, 16'd5);
        beat(8'd3, 1, 0, 0, 8'd4,  8'd1, 16'd6);
        beat(8'd3, 1, 0, 0, 8'd4,  8'd2, 16'd7);
        beat(8'd3, 1, 0, 1, 8'd4,  8'd3, 16'd8);
        chk("fault_ready_low", 32'(bus.ready), 32'd0);
        bus.valid = 1'b1;
        bus.data  = 8'd4;
        repeat (3) begin @(posedge clk); #1; end
        chk("fault_sticky", 32'({fault, locked}), 32'b10);
        chk("fault_ignores_beats", 32'(sample_count), 32'd8);
        chk("fault_err_count", 32'(err_count), 32'd3);

        // Clear in FAULT with a concurrent beat
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.valid = 1'b0;
        chk("clear_ready", 32'(bus.ready), 32'd1);
        chk("clear_flags", 32'({locked, error, fault}), 32'd0);
        chk("clear_counts", 32'({err_count, sample_count}), 32'd0);
        chk("clear_expected", 32'(expected), 32'd0);
        beat(8'd40, 0, 0, 0, 8'd41, 8'd0, 16'd1);

        // Gappy correct stream, then reset mid-stream
        do_clear();
        for (int k = 0; k < 10; k++) begin
            beat(8'(100 + k), 0, (k >= 3), 0, 8'(101 + k), 8'd0, 16'(k + 1));
            idle(int'($urandom_range(0, 2)));
        end
        bus.valid = 1'b1;
        bus.data  = 8'd110;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_reset_vals("midreset");
        bus.valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midreset", 32'(bus.ready), 32'd1);
        beat(8'd77, 0, 0, 0, 8'd78, 8'd0, 16'd1);
        idle(2);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
